multi_divider: RTL

MULTI_DIVIDER -- requirements
Module: multi_divider

---
 rtl/multi_divider_if.sv | 28 ++
 rtl/multi_divider.sv | 102 ++++++++++
 2 files changed

// File: rtl/multi_divider_if.sv
// Control and status bundle for multi_divider: per-channel enables/modes,
// the shared sync strobe, the divisor write port and the three per-channel outputs.
interface multi_divider_if #(
  parameter int CH = 4,
  parameter int W  = 16
);
  localparam int SELW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]   en;
  logic [CH-1:0]   mode;
  logic            sync;
  logic            div_we;
  logic [SELW-1:0] div_sel;
  logic [W-1:0]    div_data;
  logic [CH-1:0]   O_CLK;
  logic [CH-1:0]   O_TICK;
  logic [CH-1:0]   O_ERR;

  modport master (
    output en, mode, sync, div_we, div_sel, div_data,
    input  O_CLK, O_TICK, O_ERR
  );

  modport slave (
    input  en, mode, sync, div_we, div_sel, div_data,
    output O_CLK, O_TICK, O_ERR
  );
endinterface

// File: rtl/multi_divider.sv
// CH independent programmable clock dividers sharing one clock. Each channel has a
// shadow divisor that is adopted only at period boundaries, so periods are never cut short.
module multi_divider #(
  parameter int CH      = 4,
  parameter int W       = 16,
  parameter int DEF_DIV = 20
) (
  input logic            I_CLK,
  input logic            rst,
  multi_divider_if.slave bus
);

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] TWO     = W'(2);
  localparam logic [W:0]   ONE_X   = (W+1)'(1);
  localparam logic [W-1:0] RST_DIV = W'(DEF_DIV);

  logic [CH-1:0][W-1:0] sh_q, sh_d;
  logic [CH-1:0][W-1:0] div_q, div_d;
  logic [CH-1:0][W-1:0] cnt_q, cnt_d;
  logic [CH-1:0]        run_q, run_d;
  logic [CH-1:0]        clk_q, clk_d;
  logic [CH-1:0]        tick_q, tick_d;
  logic [CH-1:0]        err_q, err_d;

  logic [CH-1:0]        hit;
  logic [CH-1:0]        wrap;
  logic [CH-1:0]        restart;

  // run_q marks a channel that is mid-period; any cycle that is not mid-period restarts at cnt 0
  always_comb begin
    hit     = '0;
    wrap    = '0;
    restart = '0;
    for (int i = 0; i < CH; i++) begin
      hit[i]     = bus.div_we && (int'(bus.div_sel) == i);
      wrap[i]    = run_q[i] && (cnt_q[i] == (div_q[i] - ONE));
      restart[i] = bus.sync || !run_q[i] || !bus.en[i] || wrap[i];
    end
  end

  always_comb begin
    sh_d   = sh_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    err_d  = err_q;
    clk_d  = '0;
    tick_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (hit[i]) begin
        sh_d[i] = bus.div_data;
        if (bus.div_data < TWO) begin
          err_d[i] = 1'b1;
        end
      end

      // Reading sh_d lets a write landing on a wrap define the very next period
      if (restart[i]) begin
        div_d[i] = sh_d[i];
      end

      run_d[i]  = bus.en[i] && (div_d[i] >= TWO);
      cnt_d[i]  = restart[i] ? '0 : (cnt_q[i] + ONE);
      tick_d[i] = run_d[i] && (cnt_d[i] == (div_d[i] - ONE));

      if (bus.mode[i]) begin
        clk_d[i] = tick_d[i];
      end else begin
        clk_d[i] = run_d[i] &&
                   ({1'b0, cnt_d[i]} >= (({1'b0, div_d[i]} + ONE_X) >> 1));
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        sh_q[i]  <= RST_DIV;
        div_q[i] <= RST_DIV;
        cnt_q[i] <= '0;
      end
      run_q  <= '0;
      clk_q  <= '0;
      tick_q <= '0;
      err_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign bus.O_CLK  = clk_q;
  assign bus.O_TICK = tick_q;
  assign bus.O_ERR  = err_q;

endmodule
